// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: access-size encodings
// carried on ReqType and the request-handling FSM state encoding.
package data_mem_responder_pkg;

    // Access size as presented on ReqType.
    typedef enum logic [1:0] {
        WORD = 2'b00,
        HALF = 2'b01,
        BYTE = 2'b10,
        RSVD = 2'b11
    } accType_t;

    // Request-handling FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } fsmState_t;

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Combinational lane steering for little-endian sub-word accesses: store byte
// enables plus lane-replicated store data, and load extract with sign/zero
// extension.
module dmem_lane_align
    import data_mem_responder_pkg::*;
(
    input  accType_t    accType,
    input  logic [1:0]  offset,
    input  logic        isUnsigned,
    input  logic [31:0] storeData,
    input  logic [31:0] readWord,
    output logic [3:0]  byteEn,
    output logic [31:0] storeWord,
    output logic [31:0] loadData
);

    logic [15:0] halfSel;
    logic [7:0]  byteSel;

    // Steer store data into the addressed lanes and pull load data out of them.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves a latch.
        byteEn    = 4'b0000;
        storeWord = 32'h0;
        loadData  = 32'h0;
        halfSel   = offset[1] ? readWord[31:16] : readWord[15:0];
        byteSel   = readWord[8*offset +: 8];
        case (accType)
            WORD: begin
                byteEn    = 4'b1111;
                storeWord = storeData;
                loadData  = readWord;
            end
            HALF: begin
                byteEn    = offset[1] ? 4'b1100 : 4'b0011;
                storeWord = {2{storeData[15:0]}};
                loadData  = isUnsigned ? {16'h0, halfSel} : {{16{halfSel[15]}}, halfSel};
            end
            BYTE: begin
                byteEn    = 4'b0001 << offset;
                storeWord = {4{storeData[7:0]}};
                loadData  = isUnsigned ? {24'h0, byteSel} : {{24{byteSel[7]}}, byteSel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-port data memory slave: accepts one request at a time, waits a fixed
// number of cycles, performs the load/store and returns a one-cycle response.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    input  logic [1:0]  ReqType,
    input  logic        ReqUnsigned,
    output logic        RespValid,
    output logic [31:0] RespData,
    output logic        RespError,
    output logic        Busy
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    fsmState_t         state;
    logic [CNT_W-1:0]  waitCnt;
    logic              capWrite;
    accType_t          capType;
    logic              capUnsigned;
    logic [1:0]        capOffset;
    logic [IDX_W-1:0]  capIdx;
    logic [31:0]       capWData;

    logic              reqErr;
    logic              accessNow;
    logic [31:0]       readWord;
    logic [3:0]        byteEn;
    logic [31:0]       storeWord;
    logic [31:0]       loadData;

    logic [31:0]       mem [DEPTH_WORDS];

    assign ReqReady  = (state == IDLE);
    assign Busy      = (state != IDLE);
    assign accessNow = (state == WAIT) && (waitCnt == '0);
    assign readWord  = mem[capIdx];

    // Classify the incoming request as erroneous (bad size, misaligned, out of range).
    always_comb begin
        reqErr = 1'b0;
        case (accType_t'(ReqType))
            RSVD:    reqErr = 1'b1;
            HALF:    reqErr = ReqAddr[0];
            WORD:    reqErr = |ReqAddr[1:0];
            default: reqErr = 1'b0;
        endcase
        if ({2'b00, ReqAddr[31:2]} >= 32'(DEPTH_WORDS)) reqErr = 1'b1;
    end

    dmem_lane_align u_lane_align (
        .accType    (capType),
        .offset     (capOffset),
        .isUnsigned (capUnsigned),
        .storeData  (capWData),
        .readWord   (readWord),
        .byteEn     (byteEn),
        .storeWord  (storeWord),
        .loadData   (loadData)
    );

    // Request FSM: capture on accept, count wait states, issue the registered response.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            waitCnt     <= '0;
            capWrite    <= 1'b0;
            capType     <= WORD;
            capUnsigned <= 1'b0;
            capOffset   <= 2'b00;
            capIdx      <= '0;
            capWData    <= 32'h0;
            RespValid   <= 1'b0;
            RespData    <= 32'h0;
            RespError   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            RespValid <= 1'b0;
            RespData  <= 32'h0;
            RespError <= 1'b0;
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        capWrite    <= ReqWrite;
                        capType     <= accType_t'(ReqType);
                        capUnsigned <= ReqUnsigned;
                        capOffset   <= ReqAddr[1:0];
                        capIdx      <= ReqAddr[IDX_W+1:2];
                        capWData    <= ReqWData;
                        if (reqErr) begin
                            state     <= RESP;
                            RespValid <= 1'b1;
                            RespError <= 1'b1;
                        end else begin
                            state   <= WAIT;
                            waitCnt <= CNT_W'(WAIT_STATES);
                        end
                    end
                end
                WAIT: begin
                    if (waitCnt == '0) begin
                        state     <= RESP;
                        RespValid <= 1'b1;
                        RespData  <= capWrite ? 32'h0 : loadData;
                    end else begin
                        waitCnt <= waitCnt - 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Commit store lanes on the access edge; contents survive Reset.
    always_ff @(posedge Clk) begin
        // NOTE: the array has no reset branch; only the write enable depends on reset-cleared state.
        if (accessNow && capWrite) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) mem[capIdx][8*i +: 8] <= storeWord[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus random
// traffic against a byte-array reference model, and a WAIT_STATES=0 instance
// driven with ReqValid held high for the back-to-back ordering scenario.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int WS    = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;

    logic        ReqValid = 1'b0, ReqWrite = 1'b0, ReqUnsigned = 1'b0;
    logic [31:0] ReqAddr = '0, ReqWData = '0;
    logic [1:0]  ReqType = 2'b00;
    logic        ReqReady, RespValid, RespError, Busy;
    logic [31:0] RespData;

    logic        zReqValid = 1'b0, zReqWrite = 1'b0, zReqUnsigned = 1'b0;
    logic [31:0] zReqAddr = '0, zReqWData = '0;
    logic [1:0]  zReqType = 2'b00;
    logic        zReqReady, zRespValid, zRespError, zBusy;
    logic [31:0] zRespData;

    int nChecks = 0;
    int nErrors = 0;

    // Byte-addressed reference memories, one per DUT instance.
    logic [7:0] refMem [2][4*DEPTH];

    always #5 Clk = ~Clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqWrite(ReqWrite), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
        .ReqType(ReqType), .ReqUnsigned(ReqUnsigned), .RespValid(RespValid),
        .RespData(RespData), .RespError(RespError), .Busy(Busy)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .ReqValid(zReqValid), .ReqReady(zReqReady),
        .ReqWrite(zReqWrite), .ReqAddr(zReqAddr), .ReqWData(zReqWData),
        .ReqType(zReqType), .ReqUnsigned(zReqUnsigned), .RespValid(zRespValid),
        .RespData(zRespData), .RespError(zRespError), .Busy(zBusy)
    );

    // Reference behaviour: validity rules, little-endian lanes, extension.
    function automatic void refAccess(input int inst, input bit w, input logic [31:0] a,
                                      input logic [31:0] d, input logic [1:0] t, input bit u,
                                      output logic [31:0] data, output bit err);
        int size;
        logic [31:0] v;
        size = (t == 2'd0) ? 4 : (t == 2'd1) ? 2 : 1;
        err  = (t == 2'd3) || ((a % size) != 0) || ((a / 4) >= DEPTH);
        data = 32'h0;
        if (err) return;
        if (w) begin
            for (int i = 0; i < size; i++) refMem[inst][a + i] = d[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = refMem[inst][a + i];
            if (!u && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
            data = v;
        end
    endfunction

    // Issue one request on the WAIT_STATES=2 instance and check its response.
    task automatic doReq(input string name, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] t, input bit u);
        logic [31:0] expData, gotData;
        bit expErr, gotErr, seen, quietOk;
        int lat, expLat;
        refAccess(0, w, a, d, t, u, expData, expErr);
        expLat = expErr ? 0 : 1 + WS;
        @(negedge Clk);
        for (int i = 0; i < 20 && ReqReady !== 1'b1; i++) @(negedge Clk);
        ReqValid = 1'b1; ReqWrite = w; ReqAddr = a; ReqWData = d; ReqType = t; ReqUnsigned = u;
        @(posedge Clk);
        #1 ReqValid = 1'b0;
        seen = 0; quietOk = 1; lat = 0; gotData = '0; gotErr = 0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge Clk);
            if (RespValid === 1'b1) begin
                seen = 1; lat = n - 1; gotData = RespData; gotErr = RespError;
                if (ReqReady !== 1'b0) quietOk = 0;
            end else if (ReqReady !== 1'b0 || Busy !== 1'b1 || RespData !== 32'h0 || RespError !== 1'b0) begin
                quietOk = 0;
            end
        end
        nChecks++;
        if (!seen) begin
            nErrors++;
            $display("FAIL %s response: got none within 20 cycles, want one", name);
            return;
        end
        nChecks++;
        if (gotData !== expData) begin
            nErrors++; $display("FAIL %s data: got %h want %h", name, gotData, expData);
        end
        nChecks++;
        if (gotErr !== expErr) begin
            nErrors++; $display("FAIL %s error: got %0b want %0b", name, gotErr, expErr);
        end
        nChecks++;
        if (lat != expLat) begin
            nErrors++; $display("FAIL %s latency: got %0d edges want %0d", name, lat, expLat);
        end
        nChecks++;
        if (!quietOk) begin
            nErrors++; $display("FAIL %s wait outputs: got non-idle-quiet values want ReqReady=0 Busy=1 Resp*=0", name);
        end
        @(negedge Clk);
        nChecks++;
        if (RespValid !== 1'b0 || RespData !== 32'h0 || RespError !== 1'b0 || ReqReady !== 1'b1) begin
            nErrors++;
            $display("FAIL %s after pulse: got v=%b d=%h e=%b rdy=%b want 0/0/0/1",
                     name, RespValid, RespData, RespError, ReqReady);
        end
    endtask

    task automatic checkResetOutputs(input string name);
        nChecks++;
        if (ReqReady !== 1'b1 || RespValid !== 1'b0 || RespError !== 1'b0 ||
            RespData !== 32'h0 || Busy !== 1'b0) begin
            nErrors++;
            $display("FAIL %s: got rdy=%b v=%b e=%b d=%h busy=%b want 1/0/0/0/0",
                     name, ReqReady, RespValid, RespError, RespData, Busy);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        checkResetOutputs("reset_state");
        Reset = 1'b1;
        @(negedge Clk);
        checkResetOutputs("after_reset_release");
    endtask

    // Give the first 256 bytes known contents so later loads compare cleanly.
    task automatic test_init();
        for (int i = 0; i < 64; i++) doReq("init_store", 1'b1, 32'(4*i), 32'h0, 2'd0, 1'b0);
    endtask

    task automatic test_word();
        doReq("store_word_10", 1'b1, 32'h10, 32'hDEAD_BEEF, 2'd0, 1'b0);
        doReq("load_word_10",  1'b0, 32'h10, 32'h0,        2'd0, 1'b0);
    endtask

    task automatic test_byte();
        doReq("store_byte_11",  1'b1, 32'h11, 32'h0000_0080, 2'd2, 1'b0);
        doReq("load_sbyte_11",  1'b0, 32'h11, 32'h0, 2'd2, 1'b0);
        doReq("load_ubyte_11",  1'b0, 32'h11, 32'h0, 2'd2, 1'b1);
        doReq("load_word_merged", 1'b0, 32'h10, 32'h0, 2'd0, 1'b0);
        doReq("load_shalf_12",  1'b0, 32'h12, 32'h0, 2'd1, 1'b0);
        doReq("load_uhalf_10",  1'b0, 32'h10, 32'h0, 2'd1, 1'b1);
    endtask

    task automatic test_errors();
        doReq("err_half_13",   1'b0, 32'h13, 32'h0,        2'd1, 1'b0);
        doReq("err_word_12",   1'b1, 32'h12, 32'h1234_5678, 2'd0, 1'b0);
        doReq("err_rsvd_0",    1'b1, 32'h0,  32'hFFFF_FFFF, 2'd3, 1'b0);
        doReq("err_range",     1'b1, 32'(4*DEPTH), 32'hAAAA_AAAA, 2'd0, 1'b0);
        doReq("word_after_err", 1'b0, 32'h10, 32'h0,       2'd0, 1'b0);
        doReq("last_word_ok",  1'b1, 32'(4*DEPTH-4), 32'h0BAD_F00D, 2'd0, 1'b0);
        doReq("last_byte_load", 1'b0, 32'(4*DEPTH-1), 32'h0, 2'd2, 1'b1);
    endtask

    // Reset during the store's WAIT phase: the store must vanish silently.
    task automatic test_reset_mid();
        bit sawResp;
        @(negedge Clk);
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 32'h20; ReqWData = 32'h1234_5678;
        ReqType = 2'd0; ReqUnsigned = 1'b0;
        @(posedge Clk);
        #1 ReqValid = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        #1 checkResetOutputs("reset_mid_async");
        sawResp = 0;
        repeat (3) begin
            @(negedge Clk);
            if (RespValid !== 1'b0) sawResp = 1;
        end
        checkResetOutputs("reset_mid_held");
        Reset = 1'b1;
        repeat (6) begin
            @(negedge Clk);
            if (RespValid !== 1'b0) sawResp = 1;
        end
        nChecks++;
        if (sawResp) begin
            nErrors++; $display("FAIL reset_mid_no_resp: got RespValid=1 want no response");
        end
        doReq("load_after_reset", 1'b0, 32'h20, 32'h0, 2'd0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
            doReq("random", 1'($urandom_range(0, 1)), a, $urandom,
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
    endtask

    // WAIT_STATES=0 instance with ReqValid held high: two non-ready cycles
    // (WAIT, RESP) between accepts, responses in request order.
    task automatic test_back_to_back();
        logic [32:0] expQ [$];
        logic [32:0] exp;
        logic [31:0] expData, a;
        bit expErr, w;
        logic [1:0] t;
        int cyc, issued, rx, lastAcc;
        cyc = 0; issued = 0; rx = 0; lastAcc = -1;
        while (rx < 8 && cyc < 200) begin
            @(negedge Clk);
            cyc++;
            if (zRespValid === 1'b1) begin
                nChecks++;
                if (expQ.size() == 0) begin
                    nErrors++; $display("FAIL b2b_order: got unexpected response d=%h want none", zRespData);
                end else begin
                    exp = expQ.pop_front();
                    if ({zRespError, zRespData} !== exp) begin
                        nErrors++;
                        $display("FAIL b2b_resp%0d: got e=%b d=%h want e=%b d=%h",
                                 rx, zRespError, zRespData, exp[32], exp[31:0]);
                    end
                end
                rx++;
            end
            nChecks++;
            if (zBusy !== ~zReqReady) begin
                nErrors++; $display("FAIL b2b_busy: got busy=%b rdy=%b want complementary", zBusy, zReqReady);
            end
            if (zReqReady === 1'b1 && issued < 8) begin
                if (lastAcc >= 0) begin
                    nChecks++;
                    if (cyc - lastAcc != 3) begin
                        nErrors++; $display("FAIL b2b_spacing: got %0d cycles want 3", cyc - lastAcc);
                    end
                end
                w = (issued < 4);
                t = (!w && issued[0]) ? 2'd2 : 2'd0;
                a = 32'(4 * (issued % 4)) + ((t == 2'd2) ? 32'd1 : 32'd0);
                zReqWrite = w; zReqAddr = a; zReqWData = $urandom; zReqType = t; zReqUnsigned = 1'b0;
                zReqValid = 1'b1;
                refAccess(1, w, a, zReqWData, t, 1'b0, expData, expErr);
                expQ.push_back({expErr, expData});
                lastAcc = cyc;
                issued++;
            end else if (issued == 8 && zReqReady !== 1'b1) begin
                zReqValid = 1'b0;
            end
        end
        zReqValid = 1'b0;
        nChecks++;
        if (rx != 8) begin
            nErrors++; $display("FAIL b2b_count: got %0d responses want 8", rx);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int b = 0; b < 4*DEPTH; b++) refMem[k][b] = 8'h00;
        test_reset();
        test_init();
        test_word();
        test_byte();
        test_errors();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
